// File: rtl/lidar_ul_pkg.sv
// lidar_ul_pkg: shared types and constants for the pulse window gate.
//   gate_state_t     - gate FSM states
//   win_pair_t       - {odd, even} rescaled output pair
//   sample_rescale() - DATA_W -> OUT_W sample rescale
// Build option: PULSE_GATE_ROUND_EN selects round-half-up with saturation,
// otherwise plain arithmetic-shift truncation.
package lidar_ul_pkg;

    localparam int unsigned DATA_W     = 16;
    localparam int unsigned OUT_W      = 14;
    localparam int unsigned POS_W      = 16;
    localparam int unsigned TRIG_W     = 4;
    localparam int unsigned FRAME_W    = 16;
    localparam int unsigned RESCALE_SH = DATA_W - OUT_W;

    // Trigger vector bit assignments
    localparam int unsigned TRIG_PULSE = 2;
    localparam int unsigned TRIG_SW    = 0;

`ifdef PULSE_GATE_ROUND_EN
    localparam int RND_HALF = 2 ** (RESCALE_SH - 1);
    localparam int OUT_MAX  = (2 ** (OUT_W - 1)) - 1;
    localparam int OUT_MIN  = -(2 ** (OUT_W - 1));
`endif

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        CAPTURE    = 2'd2
    } gate_state_t;

    typedef struct packed {
        logic [OUT_W-1:0] odd;
        logic [OUT_W-1:0] even;
    } win_pair_t;

    // Rescale one signed, left-justified ADC sample to OUT_W bits
    function automatic logic [OUT_W-1:0] sample_rescale(input logic [DATA_W-1:0] x);
`ifdef PULSE_GATE_ROUND_EN
        int v;
        v = int'($signed(x)) + RND_HALF;
        v = v >>> RESCALE_SH;
        // Rounding can push the full-scale positive code one step past OUT_MAX
        if (v > OUT_MAX) begin
            v = OUT_MAX;
        end else if (v < OUT_MIN) begin
            v = OUT_MIN;
        end
        return OUT_W'(v);
`else
        logic signed [DATA_W-1:0] s;
        s = $signed(x) >>> RESCALE_SH;
        return OUT_W'(s);
`endif
    endfunction

endpackage

// File: rtl/pulse_window_gate_trig_edge_detect.sv
// trig_edge_detect: rising-edge detector for W trigger strobes.
//   clk_i    in   clock
//   rst_i    in   synchronous reset, active-high
//   trig_i   in   W trigger levels
//   rise_c_o out  W combinational rising-edge pulses (level vs. registered level)
module trig_edge_detect #(
    parameter int unsigned W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] trig_i,
    output logic [W-1:0] rise_c_o
);

    logic [W-1:0] r_prev;

    // Previous-cycle trigger level
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_prev <= '0;
        end else begin
            r_prev <= trig_i;
        end
    end

    // A strobe held high for several cycles yields a single pulse
    assign rise_c_o = trig_i & ~r_prev;

endmodule

// File: rtl/pulse_window_gate.sv
// pulse_window_gate: arms on the laser-pulse trigger and cuts the sample-pair
// window [start, end) out of the two-samples-per-clock ADC stream, rescaling
// each pair to OUT_W bits with valid/first/last framing.
// Build option: PULSE_GATE_ROUND_EN (see lidar_ul_pkg::sample_rescale).
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   x0_i, x0z_i        even / odd ADC sample
//   trigger_vector_i   trigger strobes, bit TRIG_BIT used
//   cfg_enable_i       arms the gate
//   cfg_start_i        first captured pair index
//   cfg_end_i          one past the last captured pair
//   win_data_o         {odd, even} rescaled pair
//   win_valid_o        pair valid, gapless for the whole window
//   win_first_o        first pair of the window
//   win_last_o         last pair of the window
//   busy_o             window armed or capturing
//   frame_cnt_o        completed windows (wraps)
//   overrun_o          sticky: trigger while busy
//   cfg_err_o          sticky: trigger with end <= start
module pulse_window_gate
    import lidar_ul_pkg::*;
#(
    parameter int unsigned TRIG_BIT = TRIG_PULSE
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [DATA_W-1:0]    x0_i,
    input  logic [DATA_W-1:0]    x0z_i,
    input  logic [TRIG_W-1:0]    trigger_vector_i,
    input  logic                 cfg_enable_i,
    input  logic [POS_W-1:0]     cfg_start_i,
    input  logic [POS_W-1:0]     cfg_end_i,
    output logic [2*OUT_W-1:0]   win_data_o,
    output logic                 win_valid_o,
    output logic                 win_first_o,
    output logic                 win_last_o,
    output logic                 busy_o,
    output logic [FRAME_W-1:0]   frame_cnt_o,
    output logic                 overrun_o,
    output logic                 cfg_err_o
);

    gate_state_t          r_state;
    gate_state_t          w_state_nxt;
    logic [POS_W-1:0]     r_pos;
    logic [POS_W-1:0]     w_pos_nxt;
    logic [POS_W-1:0]     r_start;
    logic [POS_W-1:0]     r_end;
    logic [DATA_W-1:0]    r_x0;
    logic [DATA_W-1:0]    r_x0z;
    win_pair_t            r_data;
    logic                 r_valid;
    logic                 r_first;
    logic                 r_last;
    logic                 r_busy;
    logic [FRAME_W-1:0]   r_frame_cnt;
    logic                 r_overrun;
    logic                 r_cfg_err;

    logic                 w_event;
    logic                 w_latch;
    logic                 w_take;
    logic                 w_done;
    logic                 w_first;
    logic                 w_last;
    logic                 w_set_ovr;
    logic                 w_set_err;
    logic                 w_unused_trig;

    // Pulse-trigger edge; the event is seen in the same cycle as the pair it refers to
    trig_edge_detect #(
        .W (1)
    ) u_trig_edge (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .trig_i   (trigger_vector_i[TRIG_BIT]),
        .rise_c_o (w_event)
    );

    // The remaining trigger bits belong to other consumers
    assign w_unused_trig = ^(trigger_vector_i & ~(TRIG_W'(1) << TRIG_BIT));

    // Next-state / control decode. r_pos is the index of the pair held in r_x0/r_x0z.
    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_latch     = 1'b0;
        w_take      = 1'b0;
        w_done      = 1'b0;
        w_first     = 1'b0;
        w_last      = 1'b0;
        w_set_ovr   = 1'b0;
        w_set_err   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_event && cfg_enable_i) begin
                    if (cfg_end_i > cfg_start_i) begin
                        w_latch     = 1'b1;
                        w_pos_nxt   = '0;
                        w_state_nxt = (cfg_start_i == '0) ? CAPTURE : WAIT_START;
                    end else begin
                        w_set_err = 1'b1;
                    end
                end
            end
            WAIT_START: begin
                w_pos_nxt = r_pos + POS_W'(1);
                if (r_pos == r_start - POS_W'(1)) begin
                    w_state_nxt = CAPTURE;
                end
            end
            CAPTURE: begin
                w_take    = 1'b1;
                w_first   = (r_pos == r_start);
                w_last    = (r_pos == r_end - POS_W'(1));
                w_pos_nxt = r_pos + POS_W'(1);
                if (w_last) begin
                    w_done      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Busy includes the final CAPTURE cycle, so a trigger there is an overrun too
        if (w_event && (r_state != IDLE)) begin
            w_set_ovr = 1'b1;
        end
    end

    // FSM state, position counter and latched window bounds
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_pos   <= '0;
            r_start <= '0;
            r_end   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pos   <= w_pos_nxt;
            if (w_latch) begin
                r_start <= cfg_start_i;
                r_end   <= cfg_end_i;
            end
        end
    end

    // Sample alignment stage, output register, counters and sticky flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_x0        <= '0;
            r_x0z       <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_first     <= 1'b0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_cnt <= '0;
            r_overrun   <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_x0    <= x0_i;
            r_x0z   <= x0z_i;
            r_valid <= w_take;
            r_first <= w_take && w_first;
            r_last  <= w_take && w_last;
            r_busy  <= (w_state_nxt != IDLE);
            if (w_take) begin
                r_data <= '{odd: sample_rescale(r_x0z), even: sample_rescale(r_x0)};
            end
            if (w_done) begin
                r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end
            if (w_set_ovr) begin
                r_overrun <= 1'b1;
            end
            if (w_set_err) begin
                r_cfg_err <= 1'b1;
            end
        end
    end

    assign win_data_o  = r_data;
    assign win_valid_o = r_valid;
    assign win_first_o = r_first;
    assign win_last_o  = r_last;
    assign busy_o      = r_busy;
    assign frame_cnt_o = r_frame_cnt;
    assign overrun_o   = r_overrun;
    assign cfg_err_o   = r_cfg_err;

endmodule

// File: tb/tb_pulse_window_gate.sv
// Bench for pulse_window_gate: a window-level model (trigger cycle, start, end)
// predicts every output each cycle; directed scenarios add literal checks.
module tb_pulse_window_gate;

    localparam int TB_TRIG = 2;

    logic        clk;
    logic        rst_i;
    logic [15:0] x0_i;
    logic [15:0] x0z_i;
    logic [3:0]  trigger_vector_i;
    logic        cfg_enable_i;
    logic [15:0] cfg_start_i;
    logic [15:0] cfg_end_i;
    logic [27:0] win_data_o;
    logic        win_valid_o;
    logic        win_first_o;
    logic        win_last_o;
    logic        busy_o;
    logic [15:0] frame_cnt_o;
    logic        overrun_o;
    logic        cfg_err_o;

    pulse_window_gate dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .x0_i             (x0_i),
        .x0z_i            (x0z_i),
        .trigger_vector_i (trigger_vector_i),
        .cfg_enable_i     (cfg_enable_i),
        .cfg_start_i      (cfg_start_i),
        .cfg_end_i        (cfg_end_i),
        .win_data_o       (win_data_o),
        .win_valid_o      (win_valid_o),
        .win_first_o      (win_first_o),
        .win_last_o       (win_last_o),
        .busy_o           (busy_o),
        .frame_cnt_o      (frame_cnt_o),
        .overrun_o        (overrun_o),
        .cfg_err_o        (cfg_err_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    // Rescale from first principles: floor(v / 4) (after +2 when rounding), clamped
    function automatic logic [13:0] m_resc(input logic [15:0] x);
        int v;
        int q;
        v = $signed(x);
`ifdef PULSE_GATE_ROUND_EN
        v = v + 2;
`endif
        if (v >= 0) q = v / 4;
        else        q = -((-v + 3) / 4);
`ifdef PULSE_GATE_ROUND_EN
        if (q > 8191)  q = 8191;
        if (q < -8192) q = -8192;
`endif
        return 14'(q);
    endfunction

    // Window model: accepted trigger cycle t0, bounds s/e; pair p is the pair at
    // input cycle t0+p and appears on the output at cycle t0+2+p.
    bit          seen_rst = 1'b0;
    bit          m_live   = 1'b0;
    int          m_t0     = 0;
    int          m_s      = 0;
    int          m_e      = 0;
    int          m_frames = 0;
    bit          m_ovr    = 1'b0;
    bit          m_err    = 1'b0;
    bit          m_prev   = 1'b0;
    logic [31:0] ring [8];

    // Observations of the DUT, read by the scenario code as deltas
    int          obs_valid     = 0;
    int          obs_first_n   = 0;
    int          obs_last_n    = 0;
    int          obs_busy_n    = 0;
    int          obs_first_cyc = 0;
    int          obs_last_cyc  = 0;
    logic [27:0] obs_data [4];

    always @(negedge clk) begin
        int          p;
        bit          bsy;
        bit          evld;
        bit          ev;
        logic [31:0] pr;

        p    = cyc - m_t0 - 2;
        evld = m_live && (p >= m_s) && (p < m_e);
        bsy  = m_live && (cyc >= m_t0 + 1) && (cyc <= m_t0 + m_e);
        if (m_live && (cyc == m_t0 + m_e + 1)) m_frames++;

        if (seen_rst) begin
            chk("valid", 32'(win_valid_o), 32'(evld));
            if (evld) begin
                pr = ring[(cyc - 2) % 8];
                chk("data", 32'(win_data_o), 32'({m_resc(pr[31:16]), m_resc(pr[15:0])}));
                chk("first", 32'(win_first_o), 32'(p == m_s));
                chk("last", 32'(win_last_o), 32'(p == m_e - 1));
            end
            chk("busy", 32'(busy_o), 32'(bsy));
            chk("frame_cnt", 32'(frame_cnt_o), 32'(16'(m_frames)));
            chk("overrun", 32'(overrun_o), 32'(m_ovr));
            chk("cfg_err", 32'(cfg_err_o), 32'(m_err));
        end

        if (win_valid_o === 1'b1) begin
            obs_data[obs_valid % 4] = win_data_o;
            obs_valid++;
            if (win_first_o === 1'b1) begin
                obs_first_n++;
                obs_first_cyc = cyc;
            end
            if (win_last_o === 1'b1) begin
                obs_last_n++;
                obs_last_cyc = cyc;
            end
        end
        if (busy_o === 1'b1) obs_busy_n++;

        // Apply this cycle's inputs to the model
        if (rst_i) begin
            seen_rst = 1'b1;
            m_live   = 1'b0;
            m_frames = 0;
            m_ovr    = 1'b0;
            m_err    = 1'b0;
            m_prev   = 1'b0;
        end else begin
            ev     = trigger_vector_i[TB_TRIG] && !m_prev;
            m_prev = trigger_vector_i[TB_TRIG];
            if (ev) begin
                if (bsy) begin
                    m_ovr = 1'b1;
                end else if (cfg_enable_i) begin
                    if (cfg_end_i > cfg_start_i) begin
                        m_live = 1'b1;
                        m_t0   = cyc;
                        m_s    = int'(cfg_start_i);
                        m_e    = int'(cfg_end_i);
                    end else begin
                        m_err = 1'b1;
                    end
                end
            end
        end
        ring[cyc % 8] = {x0z_i, x0_i};
        cyc++;
    end

    // ---------------- stimulus ----------------
    logic [15:0] dcyc = '0;
    int b_valid, b_first, b_last, b_busy;

    task automatic step(input logic [3:0] trig);
        @(posedge clk);
        #1;
        dcyc             = dcyc + 16'd1;
        x0_i             = 16'(dcyc * 16'd1237 + 16'd5);
        x0z_i            = 16'(dcyc * 16'd4093) ^ 16'hA5A5;
        trigger_vector_i = trig;
    endtask

    task automatic step_data(input logic [15:0] a, input logic [15:0] b, input logic [3:0] trig);
        @(posedge clk);
        #1;
        x0_i             = a;
        x0z_i            = b;
        trigger_vector_i = trig;
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'b0000);
    endtask

    task automatic pulse(input logic [3:0] bits);
        repeat (3) step(bits);
        step(4'b0000);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step(4'b0000);
        step(4'b0000);
        rst_i = 1'b0;
        step(4'b0000);
    endtask

    task automatic snap();
        b_valid = obs_valid;
        b_first = obs_first_n;
        b_last  = obs_last_n;
        b_busy  = obs_busy_n;
    endtask

    task automatic check_window(input int n, input int dly);
        chk("win_count", 32'(obs_valid - b_valid), 32'(n));
        chk("win_first_n", 32'(obs_first_n - b_first), 32'd1);
        chk("win_last_n", 32'(obs_last_n - b_last), 32'd1);
        chk("win_gapless", 32'(obs_last_cyc - obs_first_cyc), 32'(n - 1));
        chk("win_latency", 32'(obs_first_cyc - m_t0), 32'(dly));
    endtask

    initial begin
        logic [27:0] lit;
        bit          reached;

        rst_i            = 1'b1;
        x0_i             = '0;
        x0z_i            = '0;
        trigger_vector_i = '0;
        cfg_enable_i     = 1'b0;
        cfg_start_i      = '0;
        cfg_end_i        = '0;
        repeat (3) step(4'b0000);
        rst_i = 1'b0;
        step(4'b0000);

        chk("rst_valid", 32'(win_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_frame", 32'(frame_cnt_o), 32'd0);
        chk("rst_flags", 32'({overrun_o, cfg_err_o}), 32'd0);
        chk("rst_data", 32'(win_data_o), 32'd0);

        // Full window: first valid 1+430+1 after the trigger, 1250 pairs
        cfg_enable_i = 1'b1;
        cfg_start_i  = 16'd430;
        cfg_end_i    = 16'd1680;
        snap();
        pulse(4'b0100);
        idle(1700);
        check_window(1250, 432);
        chk("t1_frame", 32'(frame_cnt_o), 32'd1);

        // Non-pulse trigger bit is ignored
        snap();
        pulse(4'b0001);
        idle(50);
        chk("t2_valid", 32'(obs_valid - b_valid), 32'd0);
        chk("t2_busy", 32'(obs_busy_n - b_busy), 32'd0);
        chk("t2_flags", 32'({overrun_o, cfg_err_o}), 32'd0);

        // Second trigger 200 pairs into capture plus config churn while busy
        do_reset();
        snap();
        pulse(4'b0100);
        idle(432 + 200 - 4);
        pulse(4'b0100);
        cfg_enable_i = 1'b0;
        cfg_start_i  = 16'd5;
        cfg_end_i    = 16'd6;
        idle(1200);
        check_window(1250, 432);
        chk("t3_overrun", 32'(overrun_o), 32'd1);
        chk("t3_frame", 32'(frame_cnt_o), 32'd1);
        cfg_enable_i = 1'b1;

        // Empty window is a config error; single-pair window has first=last
        do_reset();
        cfg_start_i = 16'd430;
        cfg_end_i   = 16'd430;
        snap();
        pulse(4'b0100);
        idle(20);
        chk("t4_err", 32'(cfg_err_o), 32'd1);
        chk("t4_novalid", 32'(obs_valid - b_valid), 32'd0);
        chk("t4_nobusy", 32'(obs_busy_n - b_busy), 32'd0);
        cfg_end_i = 16'd431;
        snap();
        pulse(4'b0100);
        idle(440);
        check_window(1, 432);
        chk("t4_frame", 32'(frame_cnt_o), 32'd1);

        // Rescale corner values, window starting at pair 0
        cfg_start_i = 16'd0;
        cfg_end_i   = 16'd3;
        snap();
        step_data(16'h7FFF, 16'h8000, 4'b0100);
        step_data(16'h0002, 16'h0002, 4'b0100);
        step_data(16'hFFFF, 16'h0001, 4'b0100);
        idle(10);
        check_window(3, 2);
        lit = {14'h2000, 14'h1FFF};
        chk("resc_fullscale", 32'(obs_data[b_valid % 4]), 32'(lit));
`ifdef PULSE_GATE_ROUND_EN
        lit = {14'h0001, 14'h0001};
`else
        lit = {14'h0000, 14'h0000};
`endif
        chk("resc_small", 32'(obs_data[(b_valid + 1) % 4]), 32'(lit));
`ifdef PULSE_GATE_ROUND_EN
        lit = {14'h0000, 14'h0000};
`else
        lit = {14'h0000, 14'h3FFF};
`endif
        chk("resc_minus1", 32'(obs_data[(b_valid + 2) % 4]), 32'(lit));

        // Reset at pair 600 aborts silently, next trigger gives a full window
        do_reset();
        cfg_start_i = 16'd430;
        cfg_end_i   = 16'd1680;
        snap();
        pulse(4'b0100);
        reached = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (obs_valid - b_valid >= 600) begin
                reached = 1'b1;
                break;
            end
            step(4'b0000);
        end
        chk("t6_reach600", 32'(reached), 32'd1);
        rst_i = 1'b1;
        step(4'b0000);
        rst_i = 1'b0;
        chk("t6_valid0", 32'(win_valid_o), 32'd0);
        chk("t6_busy0", 32'(busy_o), 32'd0);
        chk("t6_frame0", 32'(frame_cnt_o), 32'd0);
        chk("t6_nolast", 32'(obs_last_n - b_last), 32'd0);
        step(4'b0000);
        snap();
        pulse(4'b0100);
        idle(1700);
        check_window(1250, 432);
        chk("t6_frame", 32'(frame_cnt_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
